// File: rtl/alu_acc_unit.sv
// Accumulator/flag stage behind the ALU: runs one ALU op per START and writes back ACC/CF/BF.
// Optional registered zero flag ZF is built when ACC_ZERO_FLAG_EN is defined.
module alu_acc_unit #(
    parameter int unsigned DWIDTH = 8,
    parameter int unsigned IWIDTH = 4
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              START,
    input  logic [IWIDTH-1:0] IN_INSTR,
    input  logic [DWIDTH-1:0] ALU_OUT,
    input  logic              ALU_COUT,
    input  logic              ALU_BOUT,
    output logic [IWIDTH-1:0] ALU_INSTR,
    output logic [DWIDTH-1:0] ACC,
    output logic              CF,
    output logic              BF,
    output logic              BUSY,
    output logic              DONE
`ifdef ACC_ZERO_FLAG_EN
    ,
    output logic              ZF
`endif
);

    localparam logic [IWIDTH-1:0] OP_SUB = IWIDTH'(4);
    localparam logic [IWIDTH-1:0] OP_ADD = IWIDTH'(5);
    localparam logic [IWIDTH-1:0] OP_DEC = IWIDTH'(8);
    localparam logic [IWIDTH-1:0] OP_INC = IWIDTH'(9);
    localparam logic [IWIDTH-1:0] OP_LD  = IWIDTH'(10);
    localparam logic [IWIDTH-1:0] OP_NOP = IWIDTH'(12);
    localparam logic [IWIDTH-1:0] OP_RST = IWIDTH'(13);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t state;

    logic acc_we_c;
    logic cf_we_c;
    logic bf_we_c;
    logic clr_c;

    // Writeback decode of the opcode held on ALU_INSTR during EXEC
    always_comb begin
        acc_we_c = 1'b0;
        cf_we_c  = 1'b0;
        bf_we_c  = 1'b0;
        clr_c    = 1'b0;
        if (ALU_INSTR <= OP_LD) begin
            acc_we_c = 1'b1;
        end
        if (ALU_INSTR == OP_ADD || ALU_INSTR == OP_INC) begin
            cf_we_c = 1'b1;
        end
        if (ALU_INSTR == OP_SUB || ALU_INSTR == OP_DEC) begin
            bf_we_c = 1'b1;
        end
        if (ALU_INSTR == OP_RST) begin
            clr_c = 1'b1;
        end
    end

    // Sequencer; ALU_INSTR doubles as the instruction register
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state     <= ST_IDLE;
            ALU_INSTR <= OP_NOP;
            ACC       <= '0;
            CF        <= 1'b0;
            BF        <= 1'b0;
            BUSY      <= 1'b0;
            DONE      <= 1'b0;
`ifdef ACC_ZERO_FLAG_EN
            ZF        <= 1'b1;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (START) begin
                        ALU_INSTR <= IN_INSTR;
                        BUSY      <= 1'b1;
                        state     <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (clr_c) begin
                        ACC <= '0;
                        CF  <= 1'b0;
                        BF  <= 1'b0;
                    end else begin
                        if (acc_we_c) ACC <= ALU_OUT;
                        if (cf_we_c)  CF  <= ALU_COUT;
                        if (bf_we_c)  BF  <= ALU_BOUT;
                    end
`ifdef ACC_ZERO_FLAG_EN
                    if (clr_c) begin
                        ZF <= 1'b1;
                    end else if (acc_we_c) begin
                        ZF <= (ALU_OUT == '0);
                    end
`endif
                    ALU_INSTR <= OP_NOP;
                    DONE      <= 1'b1;
                    state     <= ST_DONE;
                end
                ST_DONE: begin
                    DONE  <= 1'b0;
                    BUSY  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    ALU_INSTR <= OP_NOP;
                    DONE      <= 1'b0;
                    BUSY      <= 1'b0;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_acc_unit.sv
// Scoreboard bench for alu_acc_unit with a behavioural ALU closing the ACC/CF/BF loop.
// Build with ACC_ZERO_FLAG_EN defined to also check ZF.
module tb_alu_acc_unit;

    logic       CLK;
    logic       nRST;
    logic       START;
    logic [3:0] IN_INSTR;
    logic [7:0] ALU_OUT;
    logic       ALU_COUT;
    logic       ALU_BOUT;
    logic [3:0] ALU_INSTR;
    logic [7:0] ACC;
    logic       CF;
    logic       BF;
    logic       BUSY;
    logic       DONE;
`ifdef ACC_ZERO_FLAG_EN
    logic       ZF;
`endif
    logic [7:0] alu_b;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [7:0] acc;
        logic       cf;
        logic       bf;
        logic       zf;
    } exp_t;

    exp_t sb[$];
    logic model_zf = 1'b1;

    alu_acc_unit #(.DWIDTH(8), .IWIDTH(4)) dut (
        .CLK      (CLK),
        .nRST     (nRST),
        .START    (START),
        .IN_INSTR (IN_INSTR),
        .ALU_OUT  (ALU_OUT),
        .ALU_COUT (ALU_COUT),
        .ALU_BOUT (ALU_BOUT),
        .ALU_INSTR(ALU_INSTR),
        .ACC      (ACC),
        .CF       (CF),
        .BF       (BF),
        .BUSY     (BUSY),
        .DONE     (DONE)
`ifdef ACC_ZERO_FLAG_EN
        ,
        .ZF       (ZF)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Behavioural ALU: IN_A=ACC, IN_B=alu_b, Cin=CF, Bin=BF
    always_comb begin
        logic [8:0] r;
        r        = 9'h000;
        ALU_COUT = 1'b0;
        ALU_BOUT = 1'b0;
        case (ALU_INSTR)
            4'h0: r = {1'b0, ~ACC};
            4'h1: r = {1'b0, ACC ^ alu_b};
            4'h2: r = {1'b0, ACC | alu_b};
            4'h3: r = {1'b0, ACC & alu_b};
            4'h4: begin r = {1'b0, ACC} - {1'b0, alu_b} - 9'(BF); ALU_BOUT = r[8]; end
            4'h5: begin r = {1'b0, ACC} + {1'b0, alu_b} + 9'(CF); ALU_COUT = r[8]; end
            4'h6: r = {1'b0, ACC[0], ACC[7:1]};
            4'h7: r = {1'b0, ACC[6:0], ACC[7]};
            4'h8: begin r = {1'b0, ACC} - 9'(!BF); ALU_BOUT = r[8]; end
            4'h9: begin r = {1'b0, ACC} + 9'h001; ALU_COUT = r[8]; end
            4'hA: r = {1'b0, alu_b};
            default: r = 9'h000;
        endcase
        ALU_OUT = r[7:0];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_exp(input logic [3:0] op, input logic [7:0] acc, input logic cf, input logic bf);
        exp_t e;
        if (op <= 4'hA || op == 4'hD) model_zf = (acc == 8'h00);
        e.acc = acc;
        e.cf  = cf;
        e.bf  = bf;
        e.zf  = model_zf;
        sb.push_back(e);
    endtask

    // Monitor: compare the scoreboard head whenever DONE is presented
    always @(negedge CLK) begin
        if (nRST && DONE) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done: got DONE=1 expected no pending op at %0t", $time);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("acc", 32'(ACC), 32'(e.acc));
                check("cf", 32'(CF), 32'(e.cf));
                check("bf", 32'(BF), 32'(e.bf));
                check("instr_nop_in_done", 32'(ALU_INSTR), 32'h0000000C);
`ifdef ACC_ZERO_FLAG_EN
                check("zf", 32'(ZF), 32'(e.zf));
`endif
            end
        end
    end

    // One op from IDLE; also checks the BUSY/DONE pulse shape
    task automatic run_op(input logic [3:0] op, input logic [7:0] b,
                          input logic [7:0] ea, input logic ecf, input logic ebf);
        int busy_n;
        int done_n;
        @(negedge CLK);
        IN_INSTR = op;
        alu_b    = b;
        START    = 1'b1;
        push_exp(op, ea, ecf, ebf);
        @(posedge CLK);
        #1 START = 1'b0;
        busy_n = 0;
        done_n = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge CLK);
            if (BUSY) busy_n++;
            if (DONE) done_n++;
            if (!BUSY) break;
        end
        check("busy_cycles", 32'(busy_n), 32'd2);
        check("done_cycles", 32'(done_n), 32'd1);
    endtask

    initial begin
        nRST     = 1'b0;
        START    = 1'b0;
        IN_INSTR = 4'hC;
        alu_b    = 8'h00;
        repeat (2) @(negedge CLK);
        check("rst_acc", 32'(ACC), 32'h00);
        check("rst_flags", 32'({CF, BF, BUSY, DONE}), 32'h0);
        check("rst_instr", 32'(ALU_INSTR), 32'h0C);
`ifdef ACC_ZERO_FLAG_EN
        check("rst_zf", 32'(ZF), 32'h1);
`endif
        nRST = 1'b1;

        // LD
        run_op(4'hA, 8'h7F, 8'h7F, 1'b0, 1'b0);
        // Carry chain
        run_op(4'hA, 8'hFF, 8'hFF, 1'b0, 1'b0);
        run_op(4'h5, 8'h01, 8'h00, 1'b1, 1'b0);
        run_op(4'h5, 8'h00, 8'h01, 1'b0, 1'b0);
        // Borrow chain with CF=1 held across SUB/DEC
        run_op(4'hA, 8'hFF, 8'hFF, 1'b0, 1'b0);
        run_op(4'h5, 8'h01, 8'h00, 1'b1, 1'b0);
        run_op(4'h4, 8'h01, 8'hFF, 1'b1, 1'b1);
        run_op(4'h8, 8'h00, 8'hFF, 1'b1, 1'b0);
        // Logic/rotate ops and the non-writing opcodes
        run_op(4'hA, 8'h81, 8'h81, 1'b1, 1'b0);
        run_op(4'h7, 8'h00, 8'h03, 1'b1, 1'b0);
        run_op(4'h6, 8'h00, 8'h81, 1'b1, 1'b0);
        run_op(4'h1, 8'hFF, 8'h7E, 1'b1, 1'b0);
        run_op(4'h3, 8'h0F, 8'h0E, 1'b1, 1'b0);
        run_op(4'h2, 8'h30, 8'h3E, 1'b1, 1'b0);
        run_op(4'h0, 8'h00, 8'hC1, 1'b1, 1'b0);
        run_op(4'h9, 8'h00, 8'hC2, 1'b0, 1'b0);
        run_op(4'hB, 8'h55, 8'hC2, 1'b0, 1'b0);
        run_op(4'hE, 8'h55, 8'hC2, 1'b0, 1'b0);
        run_op(4'hC, 8'h55, 8'hC2, 1'b0, 1'b0);

        // START held through EXEC/DONE with the opcode swapped mid-op
        @(negedge CLK);
        IN_INSTR = 4'hA;
        alu_b    = 8'h11;
        START    = 1'b1;
        push_exp(4'hA, 8'h11, 1'b0, 1'b0);
        @(negedge CLK);
        check("hs_exec_instr", 32'(ALU_INSTR), 32'h0A);
        IN_INSTR = 4'h9;
        push_exp(4'h9, 8'h12, 1'b0, 1'b0);
        @(negedge CLK);
        check("hs_done_busy", 32'(BUSY), 32'h1);
        @(negedge CLK);
        check("hs_idle_busy", 32'(BUSY), 32'h0);
        @(negedge CLK);
        check("hs_second_busy", 32'(BUSY), 32'h1);
        check("hs_second_instr", 32'(ALU_INSTR), 32'h09);
        START = 1'b0;
        repeat (2) @(negedge CLK);
        check("hs_back_idle", 32'(BUSY), 32'h0);

        // RST opcode with ACC=0x3C, CF=BF=1
        run_op(4'hA, 8'h00, 8'h00, 1'b0, 1'b0);
        run_op(4'h4, 8'h01, 8'hFF, 1'b0, 1'b1);
        run_op(4'hA, 8'h80, 8'h80, 1'b0, 1'b1);
        run_op(4'h5, 8'h80, 8'h00, 1'b1, 1'b1);
        run_op(4'hA, 8'h3C, 8'h3C, 1'b1, 1'b1);
        run_op(4'hD, 8'hFF, 8'h00, 1'b0, 1'b0);
        run_op(4'hC, 8'hFF, 8'h00, 1'b0, 1'b0);

        // Async reset mid-EXEC after ACC=0x55, CF=1
        run_op(4'hA, 8'hFF, 8'hFF, 1'b0, 1'b0);
        run_op(4'h5, 8'h56, 8'h55, 1'b1, 1'b0);
        @(negedge CLK);
        IN_INSTR = 4'h9;
        START    = 1'b1;
        @(posedge CLK);
        #1 START = 1'b0;
        check("mid_exec_busy", 32'(BUSY), 32'h1);
        #2 nRST = 1'b0;
        #1;
        check("async_rst_acc", 32'(ACC), 32'h00);
        check("async_rst_flags", 32'({CF, BF, BUSY, DONE}), 32'h0);
        check("async_rst_instr", 32'(ALU_INSTR), 32'h0C);
`ifdef ACC_ZERO_FLAG_EN
        check("async_rst_zf", 32'(ZF), 32'h1);
`endif
        repeat (2) @(negedge CLK);
        nRST = 1'b1;
        repeat (4) @(negedge CLK);
        check("post_rst_acc", 32'(ACC), 32'h00);
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
